l2_bank_rr_arbiter: RTL and testbench

- Shares one 32-bit L2 SRAM bank between the TCDM requesters feeding the L2 subsystem: 4 AXI-to-TCDM bridge ports and 2 uDMA TCDM channels.
- Grants at most one request per cycle using round-robin priority and drives the bank's SRAM port.
- Routes the 1-cycle-latency SRAM response back to the granted requester.
- Keeps a saturating contention counter for performance monitoring.
- One instance sits in front of each of the NB_L2_BANKS banks.

---
 rtl/l2_arb_pkg.sv | 20 ++
 rtl/l2_rr_picker.sv | 48 ++++
 rtl/l2_bank_rr_arbiter.sv | 110 +++++++++++
 tb/tb_l2_bank_rr_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_arb_pkg.sv
// rtl/l2_arb_pkg.sv - shared types and constants for the L2 bank arbiter
package l2_arb_pkg;

    localparam int NB_L2_BANKS        = 4;
    localparam int L2_DATA_WIDTH      = 32;
    localparam int L2_BANK_ADDR_WIDTH = 15;

    typedef struct packed {
        logic [L2_BANK_ADDR_WIDTH-1:0] add;
        logic                          wen;
        logic [L2_DATA_WIDTH/8-1:0]    be;
        logic [L2_DATA_WIDTH-1:0]      wdata;
    } tcdm_req_t;

    typedef struct packed {
        logic                     r_valid;
        logic [L2_DATA_WIDTH-1:0] r_rdata;
    } tcdm_rsp_t;

endpackage

// File: rtl/l2_rr_picker.sv
// rtl/l2_rr_picker.sv - combinational round-robin winner search
module l2_rr_picker
    import l2_arb_pkg::*;
#(
    parameter int NumReq = 6,
    parameter int IdxW   = $clog2(NumReq)
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [IdxW-1:0]   ptr_i,
    output logic [NumReq-1:0] gnt_o,
    output logic [IdxW-1:0]   win_o,
    output logic              any_o
);

    localparam int PosW = IdxW + 1;

    logic [2*NumReq-1:0] req_dbl;
    logic [PosW-1:0]     pos;
    logic                found;

    // Lowest set bit at or above the pointer in the doubled vector; the
    // second copy supplies the wrap-around without modulo arithmetic.
    always_comb begin
        req_dbl = {req_i, req_i};
        pos     = '0;
        found   = 1'b0;
        for (int i = 2*NumReq-1; i >= 0; i--) begin
            if (req_dbl[i] && (i >= int'(ptr_i))) begin
                pos   = PosW'(i);
                found = 1'b1;
            end
        end
    end

    // Fold the doubled position back into a port index and decode it.
    always_comb begin
        if (pos >= PosW'(NumReq)) begin
            win_o = IdxW'(pos - PosW'(NumReq));
        end else begin
            win_o = IdxW'(pos);
        end
        any_o = found;
        for (int k = 0; k < NumReq; k++) begin
            gnt_o[k] = found && (win_o == IdxW'(k));
        end
    end

endmodule

// File: rtl/l2_bank_rr_arbiter.sv
// rtl/l2_bank_rr_arbiter.sv - round-robin arbiter for one L2 SRAM bank
module l2_bank_rr_arbiter
    import l2_arb_pkg::*;
#(
    parameter int NumReq    = 6,
    parameter int AddrWidth = L2_BANK_ADDR_WIDTH,
    parameter int DataWidth = L2_DATA_WIDTH,
    parameter int CntWidth  = 32
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [NumReq-1:0]                     req_i,
    input  logic [NumReq-1:0][AddrWidth-1:0]      add_i,
    input  logic [NumReq-1:0]                     wen_i,
    input  logic [NumReq-1:0][DataWidth/8-1:0]    be_i,
    input  logic [NumReq-1:0][DataWidth-1:0]      wdata_i,
    output logic [NumReq-1:0]                     gnt_o,
    output logic [NumReq-1:0]                     r_valid_o,
    output logic [NumReq-1:0][DataWidth-1:0]      r_rdata_o,
    output logic                                  mem_csn_o,
    output logic                                  mem_wen_o,
    output logic [AddrWidth-1:0]                  mem_add_o,
    output logic [DataWidth/8-1:0]                mem_be_o,
    output logic [DataWidth-1:0]                  mem_wdata_o,
    input  logic [DataWidth-1:0]                  mem_rdata_i,
    input  logic                                  clr_cnt_i,
    output logic [CntWidth-1:0]                   conflict_cnt_o
);

    localparam int IdxW = $clog2(NumReq);

    logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0]     resp_idx_q;
    logic                resp_valid_q;
    logic [IdxW-1:0]     win;
    logic                any_req;
    logic                multi_req;
    logic [CntWidth-1:0] cnt_q, cnt_d;

    l2_rr_picker #(
        .NumReq (NumReq),
        .IdxW   (IdxW)
    ) u_picker (
        .req_i  (req_i),
        .ptr_i  (rr_ptr_q),
        .gnt_o  (gnt_o),
        .win_o  (win),
        .any_o  (any_req)
    );

    // Drive the SRAM port from the winner; idle bank sees zeroed payload.
    always_comb begin
        mem_csn_o   = ~any_req;
        mem_wen_o   = 1'b1;
        mem_add_o   = '0;
        mem_be_o    = '0;
        mem_wdata_o = '0;
        if (any_req) begin
            mem_wen_o   = wen_i[win];
            mem_add_o   = add_i[win];
            mem_be_o    = be_i[win];
            mem_wdata_o = wdata_i[win];
        end
    end

    // Next pointer sits just past the winner; held when nobody asks.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (any_req) begin
            rr_ptr_d = (win == IdxW'(NumReq-1)) ? '0 : win + 1'b1;
        end
    end

    // Contention means two or more requests: clearing the lowest set bit leaves something.
    always_comb begin
        multi_req = |(req_i & (req_i - 1'b1));
        cnt_d     = cnt_q;
        if (clr_cnt_i) begin
            cnt_d = '0;
        end else if (multi_req && !(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Pointer, response tracking and contention counter state.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_ptr_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_idx_q   <= '0;
            cnt_q        <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            resp_valid_q <= any_req;
            resp_idx_q   <= win;
            cnt_q        <= cnt_d;
        end
    end

    // Response valid goes to the port granted last cycle; read data is broadcast.
    always_comb begin
        for (int k = 0; k < NumReq; k++) begin
            r_valid_o[k] = resp_valid_q && (resp_idx_q == IdxW'(k));
            r_rdata_o[k] = mem_rdata_i;
        end
    end

    assign conflict_cnt_o = cnt_q;

endmodule

// File: tb/tb_l2_bank_rr_arbiter.sv
// tb/tb_l2_bank_rr_arbiter.sv - self-checking bench for l2_bank_rr_arbiter
module tb_l2_bank_rr_arbiter;

    localparam int N  = 6;
    localparam int AW = 15;
    localparam int DW = 32;
    localparam int BW = DW/8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst_n;
    logic [N-1:0]           req;
    logic [N-1:0][AW-1:0]   add;
    logic [N-1:0]           wen;
    logic [N-1:0][BW-1:0]   be;
    logic [N-1:0][DW-1:0]   wdata;
    logic                   clr;
    logic [DW-1:0]          mrdata = '0;

    logic [N-1:0]           gnt, rvalid, gnt_b, rvalid_b;
    logic [N-1:0][DW-1:0]   rdata, rdata_b;
    logic                   csn, mwen, csn_b, mwen_b;
    logic [AW-1:0]          madd, madd_b;
    logic [BW-1:0]          mbe, mbe_b;
    logic [DW-1:0]          mwdata, mwdata_b;
    logic [31:0]            cnt;
    logic [3:0]             cnt_b;

    l2_bank_rr_arbiter #(.NumReq(N), .AddrWidth(AW), .DataWidth(DW), .CntWidth(32)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .add_i(add), .wen_i(wen), .be_i(be),
        .wdata_i(wdata), .gnt_o(gnt), .r_valid_o(rvalid), .r_rdata_o(rdata),
        .mem_csn_o(csn), .mem_wen_o(mwen), .mem_add_o(madd), .mem_be_o(mbe),
        .mem_wdata_o(mwdata), .mem_rdata_i(mrdata), .clr_cnt_i(clr), .conflict_cnt_o(cnt)
    );

    l2_bank_rr_arbiter #(.NumReq(N), .AddrWidth(AW), .DataWidth(DW), .CntWidth(4)) u_dut4 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .add_i(add), .wen_i(wen), .be_i(be),
        .wdata_i(wdata), .gnt_o(gnt_b), .r_valid_o(rvalid_b), .r_rdata_o(rdata_b),
        .mem_csn_o(csn_b), .mem_wen_o(mwen_b), .mem_add_o(madd_b), .mem_be_o(mbe_b),
        .mem_wdata_o(mwdata_b), .mem_rdata_i(mrdata), .clr_cnt_i(clr), .conflict_cnt_o(cnt_b)
    );

    logic [DW-1:0] sram    [0:2**AW-1];
    logic [DW-1:0] ref_mem [0:2**AW-1];

    always @(posedge clk) begin
        if (!csn) begin
            if (mwen) begin
                mrdata <= sram[madd];
            end else begin
                for (int b = 0; b < BW; b++) begin
                    if (mbe[b]) sram[madd][8*b +: 8] <= mwdata[8*b +: 8];
                end
            end
        end
    end

    int            n_tests = 0;
    int            n_fail  = 0;
    int            m_ptr;
    logic [N-1:0]  m_rv;
    logic          m_rd_ok;
    logic [DW-1:0] m_rdata;
    longint        m_cnt;
    int            m_cnt4;
    int            last_win;
    int            gcnt [N];
    logic [N-1:0]  pend;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs against the reference, then advance the reference.
    task automatic step();
        int           win;
        logic [N-1:0] exp_gnt;
        #1;
        win = -1;
        for (int o = 0; o < N; o++) begin
            if (win < 0 && req[(m_ptr + o) % N]) win = (m_ptr + o) % N;
        end
        exp_gnt = (win >= 0) ? N'(1 << win) : '0;
        chk("gnt", gnt, exp_gnt);
        chk("gnt_b", gnt_b, exp_gnt);
        chk("csn", csn, (win < 0));
        if (win >= 0) begin
            chk("mem_wen", mwen, wen[win]);
            chk("mem_add", madd, add[win]);
            chk("mem_be", mbe, be[win]);
            chk("mem_wdata", mwdata, wdata[win]);
        end else begin
            chk("idle_add", madd, 0);
            chk("idle_be", mbe, 0);
            chk("idle_wdata", mwdata, 0);
        end
        chk("r_valid", rvalid, m_rv);
        if (m_rd_ok) begin
            for (int k = 0; k < N; k++) chk("r_rdata", rdata[k], m_rdata);
        end
        chk("cnt", cnt, m_cnt);
        chk("cnt4", cnt_b, m_cnt4);
        last_win = win;
        @(posedge clk);
        m_rd_ok = 1'b0;
        if (win >= 0) begin
            if (wen[win]) begin
                m_rdata = ref_mem[add[win]];
                m_rd_ok = 1'b1;
            end else begin
                for (int b = 0; b < BW; b++) begin
                    if (be[win][b]) ref_mem[add[win]][8*b +: 8] = wdata[win][8*b +: 8];
                end
            end
        end
        if (!rst_n) begin
            m_ptr = 0; m_rv = '0; m_cnt = 0; m_cnt4 = 0;
        end else begin
            m_rv = exp_gnt;
            if (win >= 0) m_ptr = (win + 1) % N;
            if (clr) begin
                m_cnt = 0; m_cnt4 = 0;
            end else if ($countones(req) >= 2) begin
                if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
                if (m_cnt4 < 15) m_cnt4++;
            end
        end
        @(negedge clk);
    endtask

    task automatic set_port(input int p, input logic [AW-1:0] a, input logic w,
                            input logic [BW-1:0] b, input logic [DW-1:0] d);
        add[p] = a; wen[p] = w; be[p] = b; wdata[p] = d;
    endtask

    initial begin
        for (int i = 0; i < 2**AW; i++) begin
            sram[i] = '0; ref_mem[i] = '0;
        end
        rst_n = 1'b0; req = '0; clr = 1'b0;
        add = '0; wen = '1; be = '0; wdata = '0;
        m_ptr = 0; m_rv = '0; m_rd_ok = 1'b0; m_rdata = '0; m_cnt = 0; m_cnt4 = 0;
        pend = '0;
        @(negedge clk);

        // Reset then idle
        repeat (3) step();
        rst_n = 1'b1;
        step();
        chk("idle_gnt", gnt, 0);
        chk("idle_csn", csn, 1);
        chk("idle_rvalid", rvalid, 0);
        chk("idle_cnt", cnt, 0);

        // Full contention from pointer 0
        for (int p = 0; p < N; p++) begin
            set_port(p, AW'(16 + p), 1'b1, '1, '0);
            gcnt[p] = 0;
        end
        req = '1;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("cont_order", last_win, i % N);
            if (last_win >= 0) gcnt[last_win]++;
        end
        req = '0;
        for (int p = 0; p < N; p++) chk("cont_grants", gcnt[p], 2);
        chk("cont_cnt", cnt, 12);

        // Single read on port 2
        sram[15'h1A5] = 32'hDEADBEEF; ref_mem[15'h1A5] = 32'hDEADBEEF;
        set_port(2, 15'h1A5, 1'b1, '1, '0);
        req = 6'b000100;
        #1;
        chk("rd_gnt", gnt, 6'b000100);
        chk("rd_add", madd, 15'h1A5);
        chk("rd_wen", mwen, 1);
        step();
        req = '0;
        #1;
        chk("rd_rvalid", rvalid, 6'b000100);
        chk("rd_data", rdata[2], 32'hDEADBEEF);
        step();

        // Wrap with ports 1 and 5 after a grant to 5
        set_port(5, 15'h10, 1'b1, '1, '0);
        set_port(1, 15'h11, 1'b1, '1, '0);
        req = 6'b100000;
        step();
        req = 6'b100010;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("wrap_order", last_win, (i % 2 == 0) ? 1 : 5);
        end
        req = '0;

        // Write then readback on port 4
        set_port(4, 15'h7FFF, 1'b0, 4'b0011, 32'hA5A5A5A5);
        req = 6'b010000;
        step();
        wen[4] = 1'b1;
        #1;
        chk("wr_rvalid", rvalid, 6'b010000);
        step();
        req = '0;
        #1;
        chk("rb_rvalid", rvalid, 6'b010000);
        chk("rb_data", rdata[4], 32'h0000A5A5);
        step();

        // Counter saturation and clear priority
        set_port(0, 15'h20, 1'b1, '1, '0);
        set_port(3, 15'h21, 1'b1, '1, '0);
        req = 6'b001001;
        repeat (20) step();
        chk("sat_cnt4", cnt_b, 15);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_cnt4", cnt_b, 0);
        chk("clr_cnt", cnt, 0);
        req = '0;

        // Reset at the edge of a granted request drops its response
        set_port(0, 15'h5, 1'b1, '1, '0);
        req = 6'b000001;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        req = '0;
        #1;
        chk("rst_drop", rvalid, 0);
        step();

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < N; p++) begin
                if (!pend[p] && ($urandom % 3 == 0)) begin
                    pend[p] = 1'b1;
                    set_port(p, AW'($urandom_range(0, 31)), 1'($urandom), BW'($urandom), $urandom);
                end else if (pend[p] && ($urandom % 16 == 0)) begin
                    pend[p] = 1'b0;
                end
            end
            req   = pend;
            clr   = ($urandom % 32 == 0);
            rst_n = ($urandom % 64 != 0);
            step();
            if (last_win >= 0) pend[last_win] = 1'b0;
        end
        rst_n = 1'b1; clr = 1'b0; req = '0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
